// File: rtl/fe_fft_pkg.sv
// Shared definitions for the FFT front-end datapath: I/Q component indices,
// beat-counter sizing and the halving round/saturate helper.
package fe_fft_pkg;

  localparam int I = 0;
  localparam int Q = 1;

  // Width of a counter that walks 2*ns beats (never narrower than 1 bit).
  function automatic int cnt_w(input int ns);
    return (ns <= 1) ? 1 : $clog2(2 * ns);
  endfunction

  // Round-half-up shift right by one; only the largest positive result can
  // leave the nbw_in-bit range, so only the positive side saturates.
  function automatic int rnd_sat_shr1(input int y, input int nbw_in);
    int r;
    int pmax;
    r    = (y + 1) >>> 1;
    pmax = (1 <<< (nbw_in - 1)) - 1;
    if (r > pmax) r = pmax;
    return r;
  endfunction

  // Optional output scaling shared by the sum and difference paths.
  function automatic int scale_c(input int y, input int nbw_in, input int scale);
    return (scale != 0) ? rnd_sat_shr1(y, nbw_in) : y;
  endfunction

endpackage

// File: rtl/fe_cplx_rot_mj.sv
// Registered conditional -j rotation of a complex value followed by the
// optional 1/2 scaling; used on the butterfly difference path.
module fe_cplx_rot_mj
  import fe_fft_pkg::*;
#(
  parameter int NBW_IN = 8,
  parameter int SCALE  = 0
) (
  input  logic                                clk,
  input  logic                                rst_sync,
  input  logic                                i_en,
  input  logic                                i_rot,
  input  logic [1:0][NBW_IN:0]                i_data,
  output logic [1:0][NBW_IN-SCALE:0]          o_data
);

  localparam int W       = NBW_IN + 1;
  localparam int NBW_OUT = NBW_IN + 1 - SCALE;

  logic signed [W-1:0] d_i;
  logic signed [W-1:0] d_q;
  logic signed [W-1:0] y_i;
  logic signed [W-1:0] y_q;

  assign d_i = $signed(i_data[I]);
  assign d_q = $signed(i_data[Q]);

  // -j*(dI + j*dQ) = dQ - j*dI; |d| < 2^NBW_IN so the negation fits in W bits
  always_comb begin
    y_i = d_i;
    y_q = d_q;
    if (i_rot) begin
      y_i = d_q;
      y_q = -d_i;
    end
  end

  // Stage 2 register: scaled result, held while no beat is in flight
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      o_data <= '0;
    end else if (i_en) begin
      o_data[I] <= NBW_OUT'(scale_c(int'(y_i), NBW_IN, SCALE));
      o_data[Q] <= NBW_OUT'(scale_c(int'(y_q), NBW_IN, SCALE));
    end
  end

endmodule

// File: rtl/fe_bf2_butterfly.sv
// Radix-2^2 SDF butterfly arithmetic stage: sum/difference of the reorder
// FIFO's sample pair, -j rotation of the difference in the upper half of each
// 2*NS_FIFO beat block (type II), optional 1/2 scaling. Two-cycle latency.
module fe_bf2_butterfly
  import fe_fft_pkg::*;
#(
  parameter int NBW_IN  = 8,
  parameter int NS_FIFO = 2,
  parameter int TYPE_II = 0,
  parameter int SCALE   = 0
) (
  input  logic                               clk,
  input  logic                               rst_sync,
  input  logic                               i_valid,
  input  logic                               i_sof,
  input  logic signed [1:0][1:0][NBW_IN-1:0] i_data,
  output logic                               o_valid,
  output logic                               o_sof,
  output logic signed [1:0][1:0][NBW_IN-SCALE:0] o_data
);

  localparam int NBW_OUT = NBW_IN + 1 - SCALE;
  localparam int W1      = NBW_IN + 1;
  localparam int CW      = cnt_w(NS_FIFO);
  localparam logic [CW-1:0] NS_C   = CW'(NS_FIFO);
  localparam logic [CW-1:0] LAST_C = CW'(2 * NS_FIFO - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] idx;

  logic signed [NBW_IN-1:0] a_i, a_q, b_i, b_q;

  logic signed [W1-1:0] s_i_p1, s_q_p1, d_i_p1, d_q_p1;
  logic                 vld_p1, sof_p1, rot_p1;

  logic [1:0][NBW_OUT-1:0] sum_p2;
  logic [1:0][NBW_OUT-1:0] diff_p2;

  assign a_i = $signed(i_data[0][I]);
  assign a_q = $signed(i_data[0][Q]);
  assign b_i = $signed(i_data[1][I]);
  assign b_q = $signed(i_data[1][Q]);

  // Start of frame pins the current beat to index 0, overriding the counter
  assign idx = i_sof ? '0 : cnt;

  // Beat counter: advances per accepted beat, wraps at the block length
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      cnt <= '0;
    end else if (i_valid) begin
      cnt <= (idx == LAST_C) ? '0 : idx + 1'b1;
    end
  end

  // Stage 1 control: valid, frame marker and rotation decision
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
      rot_p1 <= 1'b0;
    end else begin
      vld_p1 <= i_valid;
      sof_p1 <= i_valid & i_sof;
      rot_p1 <= (TYPE_II != 0) && (idx >= NS_C);
    end
  end

  // Stage 1 data: full-growth sum and difference
  always_ff @(posedge clk) begin
    if (i_valid) begin
      s_i_p1 <= W1'(a_i) + W1'(b_i);
      s_q_p1 <= W1'(a_q) + W1'(b_q);
      d_i_p1 <= W1'(a_i) - W1'(b_i);
      d_q_p1 <= W1'(a_q) - W1'(b_q);
    end
  end

  // Stage 2 sum path: scaled, held while no beat is in flight
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      sum_p2 <= '0;
    end else if (vld_p1) begin
      sum_p2[I] <= NBW_OUT'(scale_c(int'(s_i_p1), NBW_IN, SCALE));
      sum_p2[Q] <= NBW_OUT'(scale_c(int'(s_q_p1), NBW_IN, SCALE));
    end
  end

  fe_cplx_rot_mj #(
    .NBW_IN (NBW_IN),
    .SCALE  (SCALE)
  ) u_rot (
    .clk      (clk),
    .rst_sync (rst_sync),
    .i_en     (vld_p1),
    .i_rot    (rot_p1),
    .i_data   ({d_q_p1, d_i_p1}),
    .o_data   (diff_p2)
  );

  // Stage 2 control: output qualifiers aligned with the data registers
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
    end else begin
      o_valid <= vld_p1;
      o_sof   <= vld_p1 & sof_p1;
    end
  end

  assign o_data = {diff_p2, sum_p2};

endmodule

// File: tb/tb_fe_bf2_butterfly.sv
// Directed bench: a type-II full-growth instance and a type-I scaled instance
// share one stimulus stream.
module tb_fe_bf2_butterfly;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_sync;
  logic                   i_valid;
  logic                   i_sof;
  logic [1:0][1:0][7:0]   i_data;

  logic                   t2_valid, t2_sof;
  logic [1:0][1:0][8:0]   t2_data;
  logic                   sc_valid, sc_sof;
  logic [1:0][1:0][7:0]   sc_data;

  int n_assert = 0;
  int n_fail   = 0;

  fe_bf2_butterfly #(.NBW_IN(8), .NS_FIFO(2), .TYPE_II(1), .SCALE(0)) u_t2 (
    .clk(clk), .rst_sync(rst_sync), .i_valid(i_valid), .i_sof(i_sof),
    .i_data(i_data), .o_valid(t2_valid), .o_sof(t2_sof), .o_data(t2_data)
  );

  fe_bf2_butterfly #(.NBW_IN(8), .NS_FIFO(2), .TYPE_II(0), .SCALE(1)) u_sc (
    .clk(clk), .rst_sync(rst_sync), .i_valid(i_valid), .i_sof(i_sof),
    .i_data(i_data), .o_valid(sc_valid), .o_sof(sc_sof), .o_data(sc_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ai, input int aq, input int bi, input int bq,
                       input logic v, input logic s);
    i_data[0][0] = 8'(ai);
    i_data[0][1] = 8'(aq);
    i_data[1][0] = 8'(bi);
    i_data[1][1] = 8'(bq);
    i_valid      = v;
    i_sof        = s;
  endtask

  task automatic chk_t2(input string tag, input logic v, input logic s,
                        input int si, input int sq, input int di, input int dq);
    chk({tag, ".t2.vld"}, int'(t2_valid), int'(v));
    chk({tag, ".t2.sof"}, int'(t2_sof), int'(s));
    chk({tag, ".t2.sI"}, int'($signed(t2_data[0][0])), si);
    chk({tag, ".t2.sQ"}, int'($signed(t2_data[0][1])), sq);
    chk({tag, ".t2.dI"}, int'($signed(t2_data[1][0])), di);
    chk({tag, ".t2.dQ"}, int'($signed(t2_data[1][1])), dq);
  endtask

  task automatic chk_sc(input string tag, input logic v, input logic s,
                        input int si, input int sq, input int di, input int dq);
    chk({tag, ".sc.vld"}, int'(sc_valid), int'(v));
    chk({tag, ".sc.sof"}, int'(sc_sof), int'(s));
    chk({tag, ".sc.sI"}, int'($signed(sc_data[0][0])), si);
    chk({tag, ".sc.sQ"}, int'($signed(sc_data[0][1])), sq);
    chk({tag, ".sc.dI"}, int'($signed(sc_data[1][0])), di);
    chk({tag, ".sc.dQ"}, int'($signed(sc_data[1][1])), dq);
  endtask

  int bidx;

  initial begin
    // Reset state
    rst_sync = 1'b1;
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    tick();
    chk_t2("rst", 1'b0, 1'b0, 0, 0, 0, 0);
    chk_sc("rst", 1'b0, 1'b0, 0, 0, 0, 0);
    rst_sync = 1'b0;
    tick();

    // Single beat with start of frame, two-cycle latency, then hold
    drive(10, -3, 4, 5, 1'b1, 1'b1);
    tick();
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    chk("t1.lat.t2", int'(t2_valid), 0);
    tick();
    chk_t2("t1", 1'b1, 1'b1, 14, 2, 6, -8);
    chk_sc("t1", 1'b1, 1'b1, 7, 1, 3, -4);
    tick();
    chk_t2("t1.hold", 1'b0, 1'b0, 14, 2, 6, -8);

    // Back-to-back beats 0..4: upper half of the block rotated
    for (int k = 0; k < 6; k++) begin
      if (k < 5) drive(10, -3, 4, 5, 1'b1, (k == 0));
      else       drive(0, 0, 0, 0, 1'b0, 1'b0);
      tick();
      if (k >= 1) begin
        bidx = (k - 1) % 4;
        if (bidx < 2)
          chk_t2($sformatf("t2.b%0d", k - 1), 1'b1, (k == 1), 14, 2, 6, -8);
        else
          chk_t2($sformatf("t2.b%0d", k - 1), 1'b1, 1'b0, 14, 2, -8, -6);
      end
    end
    tick();
    chk("t2.end.vld", int'(t2_valid), 0);

    // Extremes: rounding, saturation, full growth and rotation of -255
    drive(127, 127, -128, -128, 1'b1, 1'b0);   // index 1
    tick();
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    chk_sc("t3a", 1'b1, 1'b0, 0, 0, 127, 127);
    chk_t2("t3a", 1'b1, 1'b0, -1, -1, 255, 255);
    drive(-128, -128, -128, -128, 1'b1, 1'b0); // index 2
    tick();
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    chk_sc("t3b", 1'b1, 1'b0, -128, -128, 0, 0);
    chk_t2("t3b", 1'b1, 1'b0, -256, -256, 0, 0);
    drive(-128, -128, 127, 127, 1'b1, 1'b0);   // index 3
    tick();
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    chk_sc("t3c", 1'b1, 1'b0, 0, 0, -127, -127);
    chk_t2("t3c", 1'b1, 1'b0, -1, -1, -255, 255);

    // Valid gaps freeze the counter; start of frame overrides index 3
    drive(10, -3, 4, 5, 1'b1, 1'b1);
    tick();
    drive(10, -3, 4, 5, 1'b1, 1'b0);
    tick();
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    for (int g = 0; g < 5; g++) begin
      tick();
      if (g == 0) chk_t2("t4.b1", 1'b1, 1'b0, 14, 2, 6, -8);
      else        chk($sformatf("t4.gap%0d", g), int'(t2_valid), 0);
    end
    drive(10, -3, 4, 5, 1'b1, 1'b0);
    tick();
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    chk_t2("t4.b2", 1'b1, 1'b0, 14, 2, -8, -6);
    drive(10, -3, 4, 5, 1'b1, 1'b1);
    tick();
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    chk_t2("t4.sof", 1'b1, 1'b1, 14, 2, 6, -8);

    // Reset in the middle of a continuous stream
    drive(10, -3, 4, 5, 1'b1, 1'b0);
    tick();
    tick();
    chk_t2("t5.pre", 1'b1, 1'b0, 14, 2, 6, -8);
    rst_sync = 1'b1;
    tick();
    chk_t2("t5.rst", 1'b0, 1'b0, 0, 0, 0, 0);
    rst_sync = 1'b0;
    tick();
    chk_t2("t5.after", 1'b0, 1'b0, 0, 0, 0, 0);
    tick();
    chk_t2("t5.b0", 1'b1, 1'b0, 14, 2, 6, -8);
    tick();
    chk_t2("t5.b1", 1'b1, 1'b0, 14, 2, 6, -8);
    tick();
    chk_t2("t5.b2", 1'b1, 1'b0, 14, 2, -8, -6);
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    chk_t2("t5.b3", 1'b1, 1'b0, 14, 2, -8, -6);
    tick();
    chk("t5.end.vld", int'(t2_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
